// File: rtl/kyber_kem_ctrl.sv
// AXI4-Lite control/status block for a Kyber KEM core: launches keygen/encaps/decaps,
// measures run length, enforces an optional cycle timeout and raises a level interrupt.
module kyber_kem_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start,
    output logic [1:0]                        core_op,
    input  logic                              core_done,
    output logic                              core_abort,
    output logic                              irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] timeout_q, timeout_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        core_start_q, core_start_d;
    logic        core_abort_q, core_abort_d;
    logic        irq_q, irq_d;

    logic        wr_acc_s;
    logic        rd_acc_s;
    logic        wr_ctrl_s;
    logic        start_req_s;
    logic        start_bad_s;
    logic        start_ok_s;
    logic        busy_s;
    logic [31:0] status_s;
    logic        unused_s;

    // Ready is gated by reset so nothing handshakes while the block is held in reset.
    assign wr_acc_s    = s00_axi_aresetn & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
    assign rd_acc_s    = s00_axi_aresetn & s00_axi_arvalid & ~rvalid_q;
    assign wr_ctrl_s   = wr_acc_s & (s00_axi_awaddr[3:2] == 2'd0) & s00_axi_wstrb[0];
    assign busy_s      = (state_q != ST_IDLE);
    assign start_req_s = wr_ctrl_s & s00_axi_wdata[0];
    assign start_bad_s = start_req_s & ((s00_axi_wdata[2:1] == 2'd3) | busy_s);
    assign start_ok_s  = start_req_s & ~start_bad_s;
    assign status_s    = {26'd0, op_q, 1'b0, err_q, done_q, busy_s};
    assign unused_s    = &{1'b0, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Next-state logic: AXI channels, command decode, run FSM and counters.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        done_d       = done_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        cycles_d     = cycles_q;
        timeout_d    = timeout_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        core_start_d = 1'b0;
        core_abort_d = 1'b0;

        if (wr_acc_s) begin
            bvalid_d = 1'b1;
            bresp_d  = start_bad_s ? 2'b10 : 2'b00;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (wr_acc_s && (s00_axi_awaddr[3:2] == 2'd3)) begin
            for (int i = 0; i < 4; i++) begin
                if (s00_axi_wstrb[i]) begin
                    timeout_d[8*i +: 8] = s00_axi_wdata[8*i +: 8];
                end else begin
                    timeout_d[8*i +: 8] = timeout_q[8*i +: 8];
                end
            end
        end else begin
            timeout_d = timeout_q;
        end

        // Clear applies even alongside a rejected start; a completion in the same cycle wins below.
        if (wr_ctrl_s && s00_axi_wdata[3]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            done_d = done_q;
            err_d  = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d      = ST_START;
                    op_d         = s00_axi_wdata[2:1];
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    cnt_d        = 32'd0;
                    core_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = 32'd1;
            end
            ST_RUN: begin
                if (core_done) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    cycles_d = cnt_q;
                end else if ((timeout_q != 32'd0) && (cnt_q == timeout_q)) begin
                    state_d      = ST_IDLE;
                    err_d        = 1'b1;
                    core_abort_d = 1'b1;
                    cycles_d     = cnt_q;
                end else begin
                    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is taken from current register values, i.e. before any same-cycle write.
        if (rd_acc_s) begin
            rvalid_d = 1'b1;
            case (s00_axi_araddr[3:2])
                2'd0:    rdata_d = 32'd0;
                2'd1:    rdata_d = status_s;
                2'd2:    rdata_d = cycles_q;
                2'd3:    rdata_d = timeout_q;
                default: rdata_d = 32'd0;
            endcase
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        irq_d = done_d | err_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 32'd0;
            cycles_q     <= 32'd0;
            timeout_q    <= 32'd0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            irq_q        <= irq_d;
        end
    end

    assign s00_axi_awready = wr_acc_s;
    assign s00_axi_wready  = wr_acc_s;
    assign s00_axi_arready = rd_acc_s;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign core_start      = core_start_q;
    assign core_op         = op_q;
    assign core_abort      = core_abort_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_kyber_kem_ctrl.sv
// Directed bench for kyber_kem_ctrl: AXI register access, run/timeout/abort behaviour,
// back-pressure and mid-run reset, with hand-computed expectations.
module tb_kyber_kem_ctrl;

    logic        clk;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        core_start;
    logic [1:0]  core_op;
    logic        core_done;
    logic        core_abort;
    logic        irq;

    int          n_tests;
    int          n_fail;
    logic [31:0] rd_val;
    logic [1:0]  resp;
    logic        abort_seen;

    kyber_kem_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .core_start     (core_start),
        .core_op        (core_op),
        .core_done      (core_done),
        .core_abort     (core_abort),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a write, let it be accepted at the next edge; caller inspects bresp afterwards.
    task automatic wr_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        chk1("awready", awready, 1'b1);
        chk1("wready", wready, 1'b1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk1("bvalid", bvalid, 1'b1);
    endtask

    task automatic wr_finish();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
        wr_issue(a, d, s);
        r = bresp;
        wr_finish();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] data);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk1("rvalid", rvalid, 1'b1);
        chk2("rresp", rresp, 2'b00);
        data   = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        aresetn   = 1'b0;
        awaddr    = 4'h0;
        awvalid   = 1'b1;
        wdata     = 32'h0000_0001;
        wstrb     = 4'hF;
        wvalid    = 1'b1;
        bready    = 1'b0;
        araddr    = 4'h4;
        arvalid   = 1'b1;
        rready    = 1'b0;
        core_done = 1'b0;

        // Reset with a start write and a read pending: nothing may be accepted.
        tick();
        tick();
        tick();
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_core_abort", core_abort, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        chk2("rst_core_op", core_op, 2'd0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        aresetn = 1'b1;
        tick();
        rd(4'h4, rd_val);
        chk32("rst_status", rd_val, 32'h0000_0000);
        rd(4'hC, rd_val);
        chk32("rst_timeout", rd_val, 32'h0000_0000);
        chk1("rst_core_start_post", core_start, 1'b0);

        // Encaps run completed by core_done in the 20th run cycle.
        wr_issue(4'h0, 32'h0000_0003, 4'hF);
        chk2("enc_bresp", bresp, 2'b00);
        chk1("enc_core_start", core_start, 1'b1);
        chk2("enc_core_op", core_op, 2'd1);
        wr_finish();
        chk1("enc_core_start_pulse", core_start, 1'b0);
        abort_seen = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            abort_seen = abort_seen | core_abort;
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        abort_seen = abort_seen | core_abort;
        chk1("enc_no_abort", abort_seen, 1'b0);
        chk1("enc_irq", irq, 1'b1);
        chk2("enc_core_op_held", core_op, 2'd1);
        rd(4'h4, rd_val);
        chk32("enc_status", rd_val, 32'h0000_0012);
        rd(4'h8, rd_val);
        chk32("enc_cycles", rd_val, 32'd20);
        rd(4'h0, rd_val);
        chk32("ctrl_reads_zero", rd_val, 32'h0000_0000);

        // Keygen with TIMEOUT=5 and no completion: abort after count 5.
        wr(4'hC, 32'h0000_0005, 4'hF, resp);
        chk2("to_wr_bresp", resp, 2'b00);
        wr_issue(4'h0, 32'h0000_0001, 4'hF);
        chk1("to_irq_cleared_by_start", irq, 1'b0);
        chk2("to_core_op", core_op, 2'd0);
        wr_finish();
        abort_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            abort_seen = abort_seen | core_abort;
        end
        chk1("to_no_early_abort", abort_seen, 1'b0);
        tick();
        chk1("to_abort_pulse", core_abort, 1'b1);
        chk1("to_irq", irq, 1'b1);
        tick();
        chk1("to_abort_one_cycle", core_abort, 1'b0);
        rd(4'h4, rd_val);
        chk32("to_status", rd_val, 32'h0000_0004);
        rd(4'h8, rd_val);
        chk32("to_cycles", rd_val, 32'd5);
        wr_issue(4'h0, 32'h0000_0008, 4'hF);
        chk1("clr_irq", irq, 1'b0);
        wr_finish();
        rd(4'h4, rd_val);
        chk32("clr_status", rd_val, 32'h0000_0000);

        // Rejected starts: while busy, and with op=3 while idle.
        wr(4'hC, 32'h0000_0000, 4'hF, resp);
        wr(4'h0, 32'h0000_0003, 4'hF, resp);
        chk2("busy_first_bresp", resp, 2'b00);
        wr_issue(4'h0, 32'h0000_0001, 4'hF);
        chk2("busy_start_bresp", bresp, 2'b10);
        chk1("busy_no_core_start", core_start, 1'b0);
        chk2("busy_core_op_kept", core_op, 2'd1);
        wr_finish();
        rd(4'h4, rd_val);
        chk32("busy_status", rd_val, 32'h0000_0011);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rd(4'h4, rd_val);
        chk32("busy_done_status", rd_val, 32'h0000_0012);
        wr_issue(4'h0, 32'h0000_0007, 4'hF);
        chk2("op3_bresp", bresp, 2'b10);
        chk1("op3_no_core_start", core_start, 1'b0);
        wr_finish();
        rd(4'h4, rd_val);
        chk32("op3_status", rd_val, 32'h0000_0012);
        chk1("op3_irq", irq, 1'b1);

        // core_done in the same cycle the count reaches TIMEOUT: completion wins.
        wr(4'hC, 32'h0000_0003, 4'hF, resp);
        wr(4'h0, 32'h0000_0005, 4'hF, resp);
        chk2("tie_start_bresp", resp, 2'b00);
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk1("tie_no_abort", core_abort, 1'b0);
        chk1("tie_irq", irq, 1'b1);
        tick();
        chk1("tie_no_abort_late", core_abort, 1'b0);
        rd(4'h4, rd_val);
        chk32("tie_status", rd_val, 32'h0000_0022);
        rd(4'h8, rd_val);
        chk32("tie_cycles", rd_val, 32'd3);

        // Back-pressure on B: response held, a second write is not accepted.
        wr_issue(4'hC, 32'hAABB_CCDD, 4'h2);
        chk2("bp_bresp", bresp, 2'b00);
        awaddr  = 4'hC;
        wdata   = 32'h1111_1111;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_bvalid_hold", bvalid, 1'b1);
            chk2("bp_bresp_hold", bresp, 2'b00);
            chk1("bp_awready_low", awready, 1'b0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wr_finish();
        chk1("bp_bvalid_drop", bvalid, 1'b0);
        rd(4'hC, rd_val);
        chk32("bp_timeout_byte1", rd_val, 32'h0000_CC03);

        // Back-pressure on R: data held, a second read is not accepted.
        araddr  = 4'hC;
        arvalid = 1'b1;
        tick();
        araddr = 4'h8;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("rp_rvalid_hold", rvalid, 1'b1);
            chk32("rp_rdata_hold", rdata, 32'h0000_CC03);
            chk1("rp_arready_low", arready, 1'b0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        rready = 1'b0;
        chk1("rp_rvalid_drop", rvalid, 1'b0);

        // One-cycle reset in the middle of a run.
        wr(4'hC, 32'h0000_0000, 4'hF, resp);
        wr(4'h0, 32'h0000_0003, 4'hF, resp);
        chk2("mr_start_bresp", resp, 2'b00);
        tick();
        tick();
        tick();
        aresetn = 1'b0;
        araddr  = 4'h4;
        arvalid = 1'b1;
        tick();
        chk1("mr_arready", arready, 1'b0);
        chk1("mr_rvalid", rvalid, 1'b0);
        chk1("mr_bvalid", bvalid, 1'b0);
        chk1("mr_core_start", core_start, 1'b0);
        chk1("mr_core_abort", core_abort, 1'b0);
        chk1("mr_irq", irq, 1'b0);
        chk2("mr_core_op", core_op, 2'd0);
        arvalid = 1'b0;
        aresetn = 1'b1;
        tick();
        chk1("mr_no_abort_after", core_abort, 1'b0);
        rd(4'h4, rd_val);
        chk32("mr_status", rd_val, 32'h0000_0000);
        rd(4'h8, rd_val);
        chk32("mr_cycles", rd_val, 32'h0000_0000);
        rd(4'hC, rd_val);
        chk32("mr_timeout", rd_val, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
